// File: rtl/stream_protocol_monitor.sv
// stream_protocol_monitor
//   Passive valid/ready protocol monitor for NumChannels streams. Once valid is
//   high it must stay high, with stable data, until ready. The monitor flags
//   drop and data-change violations and stall timeouts, counts handshakes,
//   captures the first offending channel and raises a registered interrupt.
//   It never drives the links it observes.
// Ports:
//   clk_i, rst_ni        clock, async active-low reset
//   clear_i              sync clear of all flags, counters, trackers, capture
//   valid_i/ready_i      per-channel handshake taps
//   data_i               payloads, channel k at [k*DataWidth +: DataWidth]
//   err_drop_o           sticky: valid deasserted while stalled
//   err_data_o           sticky: data changed while stalled
//   err_timeout_o        sticky: stall lasted StallTimeout cycles
//   hs_count_o           saturating handshake counts, channel k at [k*CntWidth +: CntWidth]
//   first_err_valid_o    first error captured
//   first_err_chan_o     lowest channel index flagging in that first cycle
//   irq_o                registered OR of all sticky flags

module spm_chan #(
  parameter int DataWidth    = 32,
  parameter int CntWidth     = 16,
  parameter int StallTimeout = 1024
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 clear_i,
  input  logic                 valid_i,
  input  logic                 ready_i,
  input  logic [DataWidth-1:0] data_i,
  output logic                 err_drop_o,
  output logic                 err_data_o,
  output logic                 err_timeout_o,
  output logic [CntWidth-1:0]  hs_count_o,
  output logic                 new_err_o
);
  localparam int TW = (StallTimeout > 0) ? $clog2(StallTimeout + 1) : 1;
  localparam logic [TW-1:0] TMAX = TW'(StallTimeout);

  logic                 stall_q, stall_d;
  logic [DataWidth-1:0] data_q, data_d;
  logic [TW-1:0]        stall_cnt_q, stall_cnt_d;
  logic                 err_drop_q, err_drop_d;
  logic                 err_data_q, err_data_d;
  logic                 err_tmo_q, err_tmo_d;
  logic [CntWidth-1:0]  hs_cnt_q, hs_cnt_d;

  logic stall, hs, drop_ev, data_ev, tmo_ev;

  always_comb begin
    stall   = valid_i & ~ready_i;
    hs      = valid_i & ready_i;
    // stall_q only reflects a stall seen since the last reset/clear, so the
    // first cycle after either can never raise a violation.
    drop_ev = stall_q & ~valid_i;
    data_ev = stall_q & valid_i & (data_i != data_q);
    // Fires on the edge where the counter would reach StallTimeout.
    tmo_ev  = (StallTimeout > 0) && stall && (stall_cnt_q == TMAX - TW'(1));

    stall_d     = stall;
    data_d      = stall ? data_i : data_q;
    stall_cnt_d = '0;
    if (StallTimeout > 0 && stall)
      stall_cnt_d = (stall_cnt_q == TMAX) ? TMAX : stall_cnt_q + TW'(1);
    err_drop_d = err_drop_q | drop_ev;
    err_data_d = err_data_q | data_ev;
    err_tmo_d  = err_tmo_q | tmo_ev;
    hs_cnt_d   = (hs && hs_cnt_q != '1) ? hs_cnt_q + CntWidth'(1) : hs_cnt_q;

    // Clear wins over anything happening in the same cycle.
    if (clear_i) begin
      stall_d     = 1'b0;
      data_d      = '0;
      stall_cnt_d = '0;
      err_drop_d  = 1'b0;
      err_data_d  = 1'b0;
      err_tmo_d   = 1'b0;
      hs_cnt_d    = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_q     <= 1'b0;
      data_q      <= '0;
      stall_cnt_q <= '0;
      err_drop_q  <= 1'b0;
      err_data_q  <= 1'b0;
      err_tmo_q   <= 1'b0;
      hs_cnt_q    <= '0;
    end else begin
      stall_q     <= stall_d;
      data_q      <= data_d;
      stall_cnt_q <= stall_cnt_d;
      err_drop_q  <= err_drop_d;
      err_data_q  <= err_data_d;
      err_tmo_q   <= err_tmo_d;
      hs_cnt_q    <= hs_cnt_d;
    end
  end

  assign err_drop_o    = err_drop_q;
  assign err_data_o    = err_data_q;
  assign err_timeout_o = err_tmo_q;
  assign hs_count_o    = hs_cnt_q;
  assign new_err_o     = (drop_ev & ~err_drop_q) | (data_ev & ~err_data_q) | (tmo_ev & ~err_tmo_q);
endmodule

module stream_protocol_monitor #(
  parameter int NumChannels  = 4,
  parameter int DataWidth    = 32,
  parameter int CntWidth     = 16,
  parameter int StallTimeout = 1024,
  localparam int ChW = (NumChannels > 1) ? $clog2(NumChannels) : 1
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic                            clear_i,
  input  logic [NumChannels-1:0]          valid_i,
  input  logic [NumChannels-1:0]          ready_i,
  input  logic [NumChannels*DataWidth-1:0] data_i,
  output logic [NumChannels-1:0]          err_drop_o,
  output logic [NumChannels-1:0]          err_data_o,
  output logic [NumChannels-1:0]          err_timeout_o,
  output logic [NumChannels*CntWidth-1:0] hs_count_o,
  output logic                            first_err_valid_o,
  output logic [ChW-1:0]                  first_err_chan_o,
  output logic                            irq_o
);
  logic [NumChannels-1:0] new_err;

  for (genvar k = 0; k < NumChannels; k++) begin : g_chan
    spm_chan #(
      .DataWidth   (DataWidth),
      .CntWidth    (CntWidth),
      .StallTimeout(StallTimeout)
    ) u_chan (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .clear_i      (clear_i),
      .valid_i      (valid_i[k]),
      .ready_i      (ready_i[k]),
      .data_i       (data_i[k*DataWidth +: DataWidth]),
      .err_drop_o   (err_drop_o[k]),
      .err_data_o   (err_data_o[k]),
      .err_timeout_o(err_timeout_o[k]),
      .hs_count_o   (hs_count_o[k*CntWidth +: CntWidth]),
      .new_err_o    (new_err[k])
    );
  end

  logic           fe_vld_q, fe_vld_d;
  logic [ChW-1:0] fe_chan_q, fe_chan_d;
  logic           irq_q, irq_d;
  logic [ChW-1:0] lowest;

  always_comb begin
    // Descending scan so the lowest-indexed offender is the last assignment.
    lowest = '0;
    for (int k = NumChannels - 1; k >= 0; k--)
      if (new_err[k]) lowest = ChW'(k);

    fe_vld_d  = fe_vld_q;
    fe_chan_d = fe_chan_q;
    if (!fe_vld_q && |new_err) begin
      fe_vld_d  = 1'b1;
      fe_chan_d = lowest;
    end
    // Built from the registered flags, hence one cycle behind them.
    irq_d = |{err_drop_o, err_data_o, err_timeout_o};
    if (clear_i) begin
      fe_vld_d  = 1'b0;
      fe_chan_d = '0;
      irq_d     = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fe_vld_q  <= 1'b0;
      fe_chan_q <= '0;
      irq_q     <= 1'b0;
    end else begin
      fe_vld_q  <= fe_vld_d;
      fe_chan_q <= fe_chan_d;
      irq_q     <= irq_d;
    end
  end

  assign first_err_valid_o = fe_vld_q;
  assign first_err_chan_o  = fe_chan_q;
  assign irq_o             = irq_q;
endmodule

// File: tb/tb_stream_protocol_monitor.sv
// Directed self-checking bench for stream_protocol_monitor
// (4 channels, 32-bit data, 4-bit counters, StallTimeout = 8).
module tb_stream_protocol_monitor;
  localparam int NC = 4;
  localparam int DW = 32;
  localparam int CW = 4;
  localparam int ST = 8;

  logic              clk_i = 1'b0;
  logic              rst_ni;
  logic              clear_i;
  logic [NC-1:0]     valid_i, ready_i;
  logic [NC*DW-1:0]  data_i;
  logic [NC-1:0]     err_drop_o, err_data_o, err_timeout_o;
  logic [NC*CW-1:0]  hs_count_o;
  logic              first_err_valid_o;
  logic [1:0]        first_err_chan_o;
  logic              irq_o;

  int n_chk  = 0;
  int n_fail = 0;

  stream_protocol_monitor #(
    .NumChannels(NC), .DataWidth(DW), .CntWidth(CW), .StallTimeout(ST)
  ) dut (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .clear_i          (clear_i),
    .valid_i          (valid_i),
    .ready_i          (ready_i),
    .data_i           (data_i),
    .err_drop_o       (err_drop_o),
    .err_data_o       (err_data_o),
    .err_timeout_o    (err_timeout_o),
    .hs_count_o       (hs_count_o),
    .first_err_valid_o(first_err_valid_o),
    .first_err_chan_o (first_err_chan_o),
    .irq_o            (irq_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
    end
  endtask

  // One clock edge; inputs change and outputs are sampled 1 time unit later.
  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic chk_flags(input string tag, input logic [3:0] drop, input logic [3:0] dat,
                           input logic [3:0] tmo);
    chk({tag, ".drop"}, 64'(err_drop_o), 64'(drop));
    chk({tag, ".data"}, 64'(err_data_o), 64'(dat));
    chk({tag, ".tmo"},  64'(err_timeout_o), 64'(tmo));
  endtask

  task automatic do_clear();
    clear_i = 1'b1;
    step();
    clear_i = 1'b0;
  endtask

  initial begin
    rst_ni = 1'b0; clear_i = 1'b0; valid_i = '0; ready_i = '0; data_i = '0;
    step(2);
    chk_flags("reset", 4'h0, 4'h0, 4'h0);
    chk("reset.hs", 64'(hs_count_o), 64'h0);
    chk("reset.fev", 64'(first_err_valid_o), 64'h0);
    chk("reset.irq", 64'(irq_o), 64'h0);
    rst_ni = 1'b1;
    step();

    // Clean burst on ch0: five beats.
    valid_i[0] = 1'b1; ready_i[0] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      data_i[0 +: DW] = 32'h10 + 32'(i);
      step();
    end
    valid_i[0] = 1'b0; ready_i[0] = 1'b0;
    step();
    chk("burst.hs0", 64'(hs_count_o[0 +: CW]), 64'd5);
    chk_flags("burst", 4'h0, 4'h0, 4'h0);
    chk("burst.irq", 64'(irq_o), 64'h0);

    // Ch1 stalls with 0xAA, then changes data to 0xBB.
    valid_i[1] = 1'b1; data_i[DW +: DW] = 32'hAA;
    step(3);
    chk_flags("stall1", 4'h0, 4'h0, 4'h0);
    data_i[DW +: DW] = 32'hBB;
    step();
    chk_flags("dchg1", 4'h0, 4'h2, 4'h0);
    chk("dchg1.fev", 64'(first_err_valid_o), 64'h1);
    chk("dchg1.fch", 64'(first_err_chan_o), 64'h1);
    chk("dchg1.irq_lag", 64'(irq_o), 64'h0);
    ready_i[1] = 1'b1;
    step();
    chk("dchg1.irq", 64'(irq_o), 64'h1);
    chk("dchg1.hs1", 64'(hs_count_o[CW +: CW]), 64'd1);
    valid_i[1] = 1'b0; ready_i[1] = 1'b0;
    do_clear();
    chk_flags("clr1", 4'h0, 4'h0, 4'h0);
    chk("clr1.fev", 64'(first_err_valid_o), 64'h0);
    chk("clr1.irq", 64'(irq_o), 64'h0);
    chk("clr1.hs", 64'(hs_count_o), 64'h0);

    // Same cycle: ch2 drops valid, ch3 changes data.
    valid_i[3:2] = 2'b11;
    data_i[2*DW +: DW] = 32'h5; data_i[3*DW +: DW] = 32'h7;
    step(2);
    valid_i[2] = 1'b0; data_i[3*DW +: DW] = 32'h8;
    step();
    chk_flags("simul", 4'h4, 4'h8, 4'h0);
    chk("simul.fch", 64'(first_err_chan_o), 64'h2);
    ready_i[3] = 1'b1;
    step();
    valid_i[3] = 1'b0; ready_i[3] = 1'b0;
    step();
    chk("simul.fch_hold", 64'(first_err_chan_o), 64'h2);
    do_clear();

    // Timeout after exactly 8 stall cycles on ch0.
    valid_i[0] = 1'b1; data_i[0 +: DW] = 32'h33;
    step(7);
    chk_flags("tmo7", 4'h0, 4'h0, 4'h0);
    step();
    chk_flags("tmo8", 4'h0, 4'h0, 4'h1);
    chk("tmo8.fch", 64'(first_err_chan_o), 64'h0);
    ready_i[0] = 1'b1;
    step();
    valid_i[0] = 1'b0; ready_i[0] = 1'b0;
    do_clear();

    // Seven stall cycles then accepted: no timeout.
    valid_i[0] = 1'b1;
    step(7);
    ready_i[0] = 1'b1;
    step();
    valid_i[0] = 1'b0; ready_i[0] = 1'b0;
    step(2);
    chk_flags("stall7", 4'h0, 4'h0, 4'h0);
    chk("stall7.irq", 64'(irq_o), 64'h0);
    do_clear();

    // Handshake counter saturation.
    valid_i[0] = 1'b1; ready_i[0] = 1'b1;
    step(20);
    valid_i[0] = 1'b0; ready_i[0] = 1'b0;
    step();
    chk("sat.hs0", 64'(hs_count_o[0 +: CW]), 64'd15);

    // Clear coincident with a data violation on ch1: violation lost.
    valid_i[1] = 1'b1; data_i[DW +: DW] = 32'h1;
    step(2);
    data_i[DW +: DW] = 32'h2; clear_i = 1'b1;
    step();
    clear_i = 1'b0;
    chk_flags("clrcoll", 4'h0, 4'h0, 4'h0);
    chk("clrcoll.hs", 64'(hs_count_o), 64'h0);
    chk("clrcoll.fev", 64'(first_err_valid_o), 64'h0);
    chk("clrcoll.irq", 64'(irq_o), 64'h0);
    data_i[DW +: DW] = 32'h3;
    step();
    chk_flags("postclr", 4'h0, 4'h0, 4'h0);
    ready_i[1] = 1'b1;
    step();
    valid_i[1] = 1'b0; ready_i[1] = 1'b0;
    step();

    // Reset asserted mid-stall on ch0, released while data keeps changing.
    valid_i[0] = 1'b1; data_i[0 +: DW] = 32'h100;
    step(2);
    rst_ni = 1'b0;
    data_i[0 +: DW] = 32'h101;
    step();
    chk_flags("rststall", 4'h0, 4'h0, 4'h0);
    rst_ni = 1'b1; data_i[0 +: DW] = 32'h102;
    step();
    chk_flags("rel1", 4'h0, 4'h0, 4'h0);
    data_i[0 +: DW] = 32'h103;
    step();
    chk_flags("rel2", 4'h0, 4'h1, 4'h0);
    chk("rel2.fch", 64'(first_err_chan_o), 64'h0);
    chk("rel2.fev", 64'(first_err_valid_o), 64'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
